// File: rtl/wbuf_merge.sv
// wbuf_merge: coalescing store FIFO (adr/data/byteen/en/done in, mem* handshake out, chkadr/chkhit conflict check, count/full/empty status)
module wbuf_merge #(
  parameter int DEPTH = 4,
  parameter int ADRW  = 27,
  parameter int DATAW = 32,
  parameter int BYTES = DATAW / 8,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic [ADRW-1:0]  adr,
  input  logic [DATAW-1:0] data,
  input  logic [BYTES-1:0] byteen,
  input  logic             en,
  output logic             done,
  output logic [ADRW-1:0]  memadr,
  output logic [DATAW-1:0] memdata,
  output logic [BYTES-1:0] membyteen,
  output logic             memen,
  input  logic             memdone,
  input  logic [ADRW-1:0]  chkadr,
  output logic             chkhit,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [ADRW-1:0] adr_q [DEPTH];
  logic [ADRW-1:0] adr_d [DEPTH];
  logic [DATAW-1:0] data_q [DEPTH];
  logic [DATAW-1:0] data_d [DEPTH];
  logic [BYTES-1:0] ben_q [DEPTH];
  logic [BYTES-1:0] ben_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, y, h1, sel;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [ADRW-1:0] memadr_q, memadr_d;
  logic [DATAW-1:0] memdata_q, memdata_d;
  logic [BYTES-1:0] membyteen_q, membyteen_d;
  logic mhit, acc, alloc, merge, pop, ld;
  assign y = tail_q - 1'b1;
  assign h1 = head_q + 1'b1;
  assign mhit = vld_q[y] && adr_q[y] == adr && !(state_q == BUSY && y == head_q);
  assign full = cnt_q == CNTW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign done = mhit || !full || byteen == '0;
  assign acc = en && done && byteen != '0;
  assign alloc = acc && !mhit;
  assign merge = acc && mhit;
  assign pop = state_q == BUSY && memdone;
  assign memen = state_q == BUSY;
  assign memadr = memadr_q;
  assign memdata = memdata_q;
  assign membyteen = membyteen_q;
  always_comb begin
    chkhit = 1'b0;
    for (int i = 0; i < DEPTH; i++) chkhit = chkhit | (vld_q[i] && adr_q[i] == chkadr);
  end
  always_comb begin
    adr_d = adr_q;
    data_d = data_q;
    ben_d = ben_q;
    vld_d = vld_q;
    if (alloc) begin
      adr_d[tail_q] = adr;
      data_d[tail_q] = data;
      ben_d[tail_q] = byteen;
      vld_d[tail_q] = 1'b1;
    end
    if (merge) begin
      for (int b = 0; b < BYTES; b++) data_d[y][8*b +: 8] = byteen[b] ? data[8*b +: 8] : data_q[y][8*b +: 8];
      ben_d[y] = ben_q[y] | byteen;
    end
    if (pop) vld_d[head_q] = 1'b0;
  end
  // Loads read the post-edge entry image so a same-edge allocate or merge is issued intact.
  always_comb begin
    sel = state_q == IDLE ? head_q : h1;
    ld = state_q == IDLE ? vld_q[head_q] : memdone && vld_d[h1];
    state_d = ld ? BUSY : (pop ? IDLE : state_q);
    head_d = pop ? h1 : head_q;
    tail_d = tail_q + PW'(alloc);
    cnt_d = cnt_q + CNTW'(alloc) - CNTW'(pop);
    memadr_d = ld ? adr_d[sel] : memadr_q;
    memdata_d = ld ? data_d[sel] : memdata_q;
    membyteen_d = ld ? ben_d[sel] : membyteen_q;
  end
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      adr_q <= '{default: '0};
      data_q <= '{default: '0};
      ben_q <= '{default: '0};
      vld_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      memadr_q <= '0;
      memdata_q <= '0;
      membyteen_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      data_q <= data_d;
      ben_q <= ben_d;
      vld_q <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      memadr_q <= memadr_d;
      memdata_q <= memdata_d;
      membyteen_q <= membyteen_d;
    end
  end
endmodule

// File: tb/tb_wbuf_merge.sv
// tb_wbuf_merge: directed vectors against hand-computed results for wbuf_merge
module tb_wbuf_merge;
  logic ph1 = 1'b0;
  logic reset = 1'b1;
  logic [26:0] adr = '0;
  logic [31:0] data = '0;
  logic [3:0] byteen = '0;
  logic en = 1'b0;
  logic done;
  logic [26:0] memadr;
  logic [31:0] memdata;
  logic [3:0] membyteen;
  logic memen;
  logic memdone = 1'b0;
  logic [26:0] chkadr = '0;
  logic chkhit;
  logic [2:0] count;
  logic full, empty;
  int vecs = 0;
  int errs = 0;
  wbuf_merge dut (
    .ph1(ph1), .reset(reset), .adr(adr), .data(data), .byteen(byteen), .en(en), .done(done),
    .memadr(memadr), .memdata(memdata), .membyteen(membyteen), .memen(memen), .memdone(memdone),
    .chkadr(chkadr), .chkhit(chkhit), .count(count), .full(full), .empty(empty)
  );
  always #5 ph1 = ~ph1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge ph1);
    #1;
  endtask
  task automatic put(input logic [26:0] a, input logic [31:0] d, input logic [3:0] b);
    en = 1'b1;
    adr = a;
    data = d;
    byteen = b;
    #1;
    chk("put_done", done, 1);
    step();
    en = 1'b0;
  endtask
  task automatic drain();
    memdone = 1'b1;
    for (int i = 0; i < 20 && !empty; i++) step();
    memdone = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_idle", memen, 0);
  endtask
  initial begin
    #12 reset = 1'b0;
    #1;
    chk("rst_memen", memen, 0);
    chk("rst_memadr", memadr, 0);
    chk("rst_memdata", memdata, 0);
    chk("rst_memben", membyteen, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_done", done, 1);
    chk("rst_chkhit", chkhit, 0);
    put(27'h10, 32'hAABBCCDD, 4'hF);
    chk("t1_memen_n", memen, 0);
    chk("t1_count1", count, 1);
    step();
    chk("t1_memen_n1", memen, 1);
    chk("t1_memadr", memadr, 27'h10);
    chk("t1_memdata", memdata, 32'hAABBCCDD);
    chk("t1_memben", membyteen, 4'hF);
    memdone = 1'b1;
    step();
    memdone = 1'b0;
    chk("t1_count0", count, 0);
    chk("t1_empty", empty, 1);
    chk("t1_idle", memen, 0);
    for (int i = 0; i < 4; i++) put(27'h20 + 27'(i), 32'h100 * i, 4'hF);
    chk("t2_full", full, 1);
    chk("t2_count", count, 4);
    chk("t2_memadr", memadr, 27'h20);
    en = 1'b1;
    adr = 27'h30;
    data = 32'h30303030;
    byteen = 4'hF;
    #1;
    chk("t2_done_full", done, 0);
    memdone = 1'b1;
    #1;
    chk("t2_done_popping", done, 0);
    step();
    memdone = 1'b0;
    #1;
    chk("t2_count3", count, 3);
    chk("t2_done_after", done, 1);
    chk("t2_next_adr", memadr, 27'h21);
    step();
    en = 1'b0;
    chk("t2_count4", count, 4);
    chk("t2_full2", full, 1);
    drain();
    put(27'h40, 32'h00001122, 4'h3);
    chk("t3_count_a", count, 1);
    put(27'h40, 32'h33440000, 4'hC);
    chk("t3_count_b", count, 1);
    chk("t3_memadr", memadr, 27'h40);
    chk("t3_memdata", memdata, 32'h33441122);
    chk("t3_memben", membyteen, 4'hF);
    drain();
    put(27'h50, 32'h00000011, 4'h1);
    put(27'h60, 32'h66666666, 4'hF);
    put(27'h50, 32'h00002200, 4'h2);
    chk("t4_count", count, 3);
    chk("t4_adr0", memadr, 27'h50);
    chk("t4_ben0", membyteen, 4'h1);
    memdone = 1'b1;
    step();
    chk("t4_adr1", memadr, 27'h60);
    step();
    chk("t4_adr2", memadr, 27'h50);
    chk("t4_ben2", membyteen, 4'h2);
    chk("t4_data2", memdata, 32'h00002200);
    step();
    memdone = 1'b0;
    chk("t4_empty", empty, 1);
    put(27'h70, 32'h77777777, 4'hF);
    step();
    chk("t5_memen", memen, 1);
    chkadr = 27'h70;
    #1;
    chk("t5_hit", chkhit, 1);
    chkadr = 27'h71;
    #1;
    chk("t5_miss", chkhit, 0);
    put(27'h70, 32'h12345678, 4'hF);
    chk("t5_inflight_alloc", count, 2);
    chkadr = 27'h70;
    memdone = 1'b1;
    step();
    chk("t5_count1", count, 1);
    chk("t5_hit2", chkhit, 1);
    chk("t5_memdata2", memdata, 32'h12345678);
    step();
    memdone = 1'b0;
    #1;
    chk("t5_hit_gone", chkhit, 0);
    chk("t5_count0", count, 0);
    en = 1'b1;
    adr = 27'h80;
    byteen = 4'h0;
    #1;
    chk("t6_done_zero_be", done, 1);
    step();
    en = 1'b0;
    chk("t6_count", count, 0);
    memdone = 1'b1;
    step();
    memdone = 1'b0;
    chk("t6_memdone_idle", memen, 0);
    put(27'h90, 32'h99999999, 4'hF);
    step();
    chk("t6_busy", memen, 1);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_memen", memen, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1);
    #2 reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
